sha256_stream_node: RTL
=======================

SHA256_STREAM_NODE -- requirements
Module: sha256_stream_node

Interface
REQ-001 Parameter ring_width_p, default 32, ring word width; SHALL be 32, 64 or 128.
REQ-002 Parameter id_p, default 0, node identifier; carried for ring integration, no functional effect.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  node enable; low SHALL stall the node.
REQ-006 v_i  input  1  input word valid.
REQ-007 data_i  input  ring_width_p  message word, most significant word of the block first.
REQ-008 last_i  input  1  final block of the message; sampled only on the final word of a block.
REQ-009 mode_i  input  1  0 = SHA-256, 1 = SHA-224; sampled only on the first word of a message.
REQ-010 ready_o  output  1  node accepts a word; transfer when v_i & ready_o.
REQ-011 v_o  output  1  digest word valid.
REQ-012 data_o  output  ring_width_p  digest word, H0 first.
REQ-013 last_o  output  1  marks the final digest word.
REQ-014 yumi_i  input  1  consumer takes data_o; legal only while v_o=1.

Function
REQ-015 Inputs SHALL be pre-padded 512-bit blocks; BW = 512/ring_width_p words per block.
REQ-016 FSM states SHALL be IDLE, LOAD, COMP and OUT.
REQ-017 IDLE: ready_o=1; on transfer, chaining register H <= IV for mode_i, mode latched, word stored, count=1, go to LOAD.
REQ-018 LOAD: ready_o=1; each transfer stores one word; on the transfer with count=BW-1, last_i is latched, a one-cycle start is pulsed to the compressor, and the FSM goes to COMP.
REQ-019 COMP: ready_o=0; on the compressor done pulse, H <= returned hash (compressor performs the feed-forward add mod 2^32 per word).
REQ-020 COMP exit: if latched last=1, go to OUT; otherwise go to LOAD with count=0 and keep H for chaining.
REQ-021 OUT: v_o=1 and data_o = current digest word; each yumi_i advances the word; the output word count is ND = ceil(DB/ring_width_p), with DB=256 for SHA-256 and DB=224 for SHA-224.
REQ-022 For SHA-224 with ring_width_p>32, bits below bit 224 of the concatenated digest in the last word SHALL be 0.
REQ-023 last_o SHALL equal 1 only while the final digest word is presented; yumi_i on that word returns the FSM to IDLE.
REQ-024 data_o and last_o SHALL hold stable while v_o=1 and yumi_i=0.
REQ-025 en_i=0 SHALL force ready_o=0 and v_o=0, ignore v_i and yumi_i, and freeze the FSM and counters; an in-flight compression continues and its done pulse is captured.
REQ-026 Latency SHALL be compressor latency + 1 cycle from the final-block last word transfer to v_o=1.
REQ-027 A single-block message (last_i=1 on the first block) SHALL be supported.
REQ-028 last_i on a non-final word of a block SHALL be ignored.
REQ-029 A new message in IDLE SHALL always reload the IV, with no carry-over from the prior H.

Reset
REQ-030 On reset_n_i=0, the node SHALL immediately enter IDLE.
REQ-031 On reset_n_i=0, all counters, H and mode SHALL clear to 0.
REQ-032 On reset_n_i=0, outputs SHALL be ready_o=0, v_o=0, last_o=0 and data_o=0.
REQ-033 Reset SHALL be asserted into the compressor, aborting any in-progress message.
REQ-034 After release, ready_o SHALL rise on the first clock edge with en_i=1.

Structure
REQ-035 A shared package sha256_pkg SHALL hold the state enum, IV constants for both modes, and block/digest width constants.
REQ-036 A shared package sha256_pkg SHALL hold the compressor port typedefs.
REQ-037 One sub-module sha256_compress SHALL be instantiated: iterative 64-round, start/done, 512-bit block in, 256-bit hash in/out.
REQ-038 All other logic (FSM, block buffer, H register, output mux) SHALL be in this module.

Verification
REQ-039 Scenario: "abc" padded, SHA-256, ring_width_p=32 -> 8 words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, last_o on the 8th.
REQ-040 Scenario: "abc", SHA-224 -> 7 words 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7; with ring_width_p=64, 4 words, the last = e36c9da7_00000000.
REQ-041 Scenario: 448-bit "abcdbcdecdefdefg...nopq", 2 blocks -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-042 Scenario: random v_i gaps and yumi_i held low 5 cycles per word -> same digest, data_o stable while waiting, no words dropped or duplicated.
REQ-043 Scenario: reset_n_i pulsed in LOAD after 7 words, then a fresh "abc" -> the correct digest with no residue.
REQ-044 Scenario: en_i low 10 cycles during LOAD, during COMP and during OUT -> ready_o=0 and v_o=0 throughout; the digest is unchanged after en_i returns.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256/224 stream node and its compressor:
//   FSM state codes, initial hash values for both modes, block and digest
//   widths, the round constant table and the compressor port structures.
package sha256_pkg;

  localparam int BLOCK_BITS_C     = 512;
  localparam int DIGEST256_BITS_C = 256;
  localparam int DIGEST224_BITS_C = 224;
  localparam int ROUNDS_C         = 64;

  // Node FSM state codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_COMP = 2'd2;
  localparam state_t ST_OUT  = 2'd3;

  // Initial chaining values, H0 in the most significant word
  localparam logic [255:0] IV256_C = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] IV224_C = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K_C [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Compressor request: start pulse, message block (word 0 at the top), chaining value in
  typedef struct packed {
    logic         start;
    logic [511:0] block;
    logic [255:0] hash;
  } comp_req_t;

  // Compressor response: one-cycle done pulse, feed-forward-added hash
  typedef struct packed {
    logic         done;
    logic [255:0] hash;
  } comp_rsp_t;

endpackage

// File: rtl/sha256_compress.sv
// sha256_compress
//   Iterative SHA-256 compression function, one round per clock.
//   Ports:
//     clk_i      clock
//     reset_n_i  asynchronous active-low reset
//     req_i      start pulse, 512-bit block, 256-bit chaining value
//     rsp_o      done pulse and chaining value + working state (mod 2^32 per word)
//   Timing: start sampled at edge N, 64 rounds on edges N+1..N+64, done is
//   high (with a valid hash) for the cycle after edge N+64.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  comp_req_t req_i,
  output comp_rsp_t rsp_o
);

  // Working variables a..h live in st[0]..st[7]
  logic [7:0][31:0]  st_q, st_d;
  // Sliding 16-word message schedule window; w[0] is the word for this round
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      hv_q, hv_d;
  logic [5:0]        rnd_q, rnd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0] big_s1, ch, t1, big_s0, maj, t2, w_new;
  logic [255:0] hash_out;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign big_s1 = rotr(st_q[4], 6) ^ rotr(st_q[4], 11) ^ rotr(st_q[4], 25);
  assign ch     = (st_q[4] & st_q[5]) ^ (~st_q[4] & st_q[6]);
  assign t1     = st_q[7] + big_s1 + ch + K_C[rnd_q] + w_q[0];
  assign big_s0 = rotr(st_q[0], 2) ^ rotr(st_q[0], 13) ^ rotr(st_q[0], 22);
  assign maj    = (st_q[0] & st_q[1]) ^ (st_q[0] & st_q[2]) ^ (st_q[1] & st_q[2]);
  assign t2     = big_s0 + maj;
  // Schedule word 16 positions ahead of the current one
  assign w_new  = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  always_comb begin
    st_d   = st_q;
    w_d    = w_q;
    hv_d   = hv_q;
    rnd_d  = rnd_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (req_i.start) begin
      busy_d = 1'b1;
      rnd_d  = 6'd0;
      hv_d   = req_i.hash;
      for (int i = 0; i < 8; i++) st_d[i] = req_i.hash[255 - 32*i -: 32];
      for (int i = 0; i < 16; i++) w_d[i] = req_i.block[511 - 32*i -: 32];
    end else if (busy_q) begin
      st_d[7] = st_q[6];
      st_d[6] = st_q[5];
      st_d[5] = st_q[4];
      st_d[4] = st_q[3] + t1;
      st_d[3] = st_q[2];
      st_d[2] = st_q[1];
      st_d[1] = st_q[0];
      st_d[0] = t1 + t2;
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
      w_d[15] = w_new;
      rnd_d   = rnd_q + 6'd1;
      if (rnd_q == 6'(ROUNDS_C - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      st_q   <= '0;
      w_q    <= '0;
      hv_q   <= '0;
      rnd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      w_q    <= w_d;
      hv_q   <= hv_d;
      rnd_q  <= rnd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Feed-forward add, word by word
  for (genvar gi = 0; gi < 8; gi++) begin : g_ff
    assign hash_out[255 - 32*gi -: 32] = hv_q[255 - 32*gi -: 32] + st_q[gi];
  end

  assign rsp_o.done = done_q;
  assign rsp_o.hash = hash_out;

endmodule

// File: rtl/sha256_stream_node.sv
// sha256_stream_node
//   Streams pre-padded 512-bit blocks in as ring words, hashes them with
//   SHA-256 or SHA-224, and streams the digest back out H0 first.
//   Ports:
//     clk_i, reset_n_i        clock, asynchronous active-low reset
//     en_i                    node enable; low stalls handshakes and FSM
//     v_i/data_i/ready_o      input word stream (transfer on v_i & ready_o)
//     last_i                  final block flag, sampled on a block's last word
//     mode_i                  0 = SHA-256, 1 = SHA-224, sampled on first word
//     v_o/data_o/last_o       digest word stream, last_o on the final word
//     yumi_i                  consumer accepts data_o
module sha256_stream_node
  import sha256_pkg::*;
#(
  parameter int ring_width_p = 32,
  parameter int id_p         = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  input  logic                    last_i,
  input  logic                    mode_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  output logic                    last_o,
  input  logic                    yumi_i
);

  localparam int BW    = BLOCK_BITS_C / ring_width_p;
  localparam int CW    = $clog2(BW);
  localparam int NW    = DIGEST256_BITS_C / ring_width_p;
  localparam int ND224 = (DIGEST224_BITS_C + ring_width_p - 1) / ring_width_p;
  localparam int OW    = $clog2(NW);

  localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);
  localparam logic [OW-1:0] OUT_LAST256 = OW'(NW - 1);
  localparam logic [OW-1:0] OUT_LAST224 = OW'(ND224 - 1);

  // The node id only tags this instance on the ring
  logic [31:0] unused_id;
  assign unused_id = 32'(id_p);

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [OW-1:0]                    ocnt_q, ocnt_d;
  logic [255:0]                     h_q, h_d;
  logic                             mode_q, mode_d;
  logic                             last_q, last_d;
  logic [BW-1:0][ring_width_p-1:0]  blk_q, blk_d;
  logic                             start_q, start_d;
  logic                             done_seen_q, done_seen_d;
  logic                             alive_q, alive_d;

  comp_req_t comp_req;
  comp_rsp_t comp_rsp;

  logic                            xfer;
  logic [OW-1:0]                   out_last;
  logic [NW-1:0][ring_width_p-1:0] dig_words;

  // alive_q holds ready_o low out of reset until the first enabled edge
  assign ready_o  = en_i & alive_q & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  assign v_o      = en_i & (state_q == ST_OUT);
  assign xfer     = v_i & ready_o;
  assign out_last = mode_q ? OUT_LAST224 : OUT_LAST256;
  assign last_o   = v_o & (ocnt_q == out_last);

  // SHA-224 truncates H7, so it reads as zero in the concatenated digest
  assign dig_words = mode_q ? {h_q[255:32], 32'h0} : h_q;
  assign data_o    = (state_q == ST_OUT) ? dig_words[OUT_LAST256 - ocnt_q] : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ocnt_d      = ocnt_q;
    h_d         = h_q;
    mode_d      = mode_q;
    last_d      = last_q;
    blk_d       = blk_q;
    start_d     = 1'b0;
    done_seen_d = done_seen_q;
    alive_d     = alive_q | en_i;

    // The done pulse is captured even while stalled; the FSM moves on later
    if ((state_q == ST_COMP) && comp_rsp.done) begin
      h_d         = comp_rsp.hash;
      done_seen_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          h_d            = mode_i ? IV224_C : IV256_C;
          mode_d         = mode_i;
          blk_d[BW - 1]  = data_i;
          cnt_d          = CW'(1);
          state_d        = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          blk_d[CNT_LAST - cnt_q] = data_i;
          if (cnt_q == CNT_LAST) begin
            last_d  = last_i;
            start_d = 1'b1;
            state_d = ST_COMP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_COMP: begin
        if (en_i && (comp_rsp.done || done_seen_q)) begin
          done_seen_d = 1'b0;
          if (last_q) begin
            ocnt_d  = '0;
            state_d = ST_OUT;
          end else begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_OUT: begin
        if (v_o && yumi_i) begin
          if (ocnt_q == out_last) begin
            ocnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            ocnt_d = ocnt_q + OW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ocnt_q      <= '0;
      h_q         <= '0;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      blk_q       <= '0;
      start_q     <= 1'b0;
      done_seen_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      h_q         <= h_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      blk_q       <= blk_d;
      start_q     <= start_d;
      done_seen_q <= done_seen_d;
      alive_q     <= alive_d;
    end
  end

  assign comp_req.start = start_q;
  assign comp_req.block = blk_q;
  assign comp_req.hash  = h_q;

  sha256_compress u_compress (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .req_i     (comp_req),
    .rsp_o     (comp_rsp)
  );

endmodule
